score_ctrl: RTL and testbench

//  Game-state sequencer that owns the score and ball counters shown by the text overlay.

---
 rtl/score_pkg.sv | 10 +
 rtl/bcd_cnt2.sv | 47 ++++
 rtl/score_ctrl.sv | 110 +++++++++++
 tb/tb_score_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types for the score/ball sequencer: FSM state encoding and BCD digit type.
package score_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD incrementer that saturates at a BCD-encoded maximum.
module bcd_cnt2
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] max,
  output bcd_t       tens,
  output bcd_t       ones
);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;

  // Valid BCD pairs order the same as plain binary, so the saturation test is a direct compare.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc && ({tens_q, ones_q} < max)) begin
      if (ones_q >= BCD_MAX) begin
        ones_d = '0;
        tens_d = (tens_q >= BCD_MAX) ? BCD_MAX : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/score_ctrl.sv
// Game-state sequencer: owns score and ball counters and publishes them to the
// text overlay only at frame boundaries.
module score_ctrl
  import score_pkg::*;
#(
  parameter int unsigned BALLS     = 3,
  parameter logic [7:0]  MAX_SCORE = 8'h99
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic start,
  input  logic hit,
  input  logic miss,
  input  logic restart,
  output bcd_t dig1,
  output bcd_t dig0,
  output bcd_t dig,
  output logic game_over,
  output logic playing
);

  localparam bcd_t BALLS_BCD = bcd_t'(BALLS);

  state_t state_q, state_d;
  bcd_t   balls_q, balls_d;
  logic   sc_clr, sc_inc;
  bcd_t   sc_tens, sc_ones;

  bcd_t   dig1_q, dig0_q, dig_q;
  logic   game_over_q;

  bcd_cnt2 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .max   (MAX_SCORE),
    .tens  (sc_tens),
    .ones  (sc_ones)
  );

  always_comb begin
    state_d = state_q;
    balls_d = balls_q;
    sc_clr  = 1'b0;
    sc_inc  = 1'b0;
    if (restart) begin
      state_d = IDLE;
      balls_d = BALLS_BCD;
      sc_clr  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = PLAY;
            balls_d = BALLS_BCD;
            sc_clr  = 1'b1;
          end
        end
        PLAY: begin
          // A hit on the last ball still scores before the game ends.
          sc_inc = hit;
          if (miss) begin
            if (balls_q <= 4'd1) begin
              balls_d = '0;
              state_d = OVER;
            end else begin
              balls_d = balls_q - 4'd1;
            end
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      balls_q <= BALLS_BCD;
    end else begin
      state_q <= state_d;
      balls_q <= balls_d;
    end
  end

  // Shadow copy samples the pre-update working values, so same-cycle events wait a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig1_q      <= '0;
      dig0_q      <= '0;
      dig_q       <= BALLS_BCD;
      game_over_q <= 1'b0;
    end else if (frame_tick) begin
      dig1_q      <= sc_tens;
      dig0_q      <= sc_ones;
      dig_q       <= balls_q;
      game_over_q <= (state_q == OVER);
    end
  end

  assign dig1      = dig1_q;
  assign dig0      = dig0_q;
  assign dig       = dig_q;
  assign game_over = game_over_q;
  assign playing   = (state_q == PLAY);

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: vector table for single-cycle behaviour plus
// hand sequences for BCD carry, saturation and asynchronous reset.
module tb_score_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick, start, hit, miss, restart;
  logic [3:0] dig1, dig0, dig;
  logic       game_over, playing;

  int tests;
  int fails;

  typedef struct {
    logic [4:0] in;   // {start, hit, miss, restart, frame_tick}
    logic [3:0] e1, e0, eb;
    logic       ego, epl;
  } vec_t;

  vec_t vq[$];

  score_ctrl #(.BALLS(3), .MAX_SCORE(8'h99)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .restart    (restart),
    .dig1       (dig1),
    .dig0       (dig0),
    .dig        (dig),
    .game_over  (game_over),
    .playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e1, input logic [3:0] e0,
                         input logic [3:0] eb, input logic ego, input logic epl);
    chk({tag, ".dig1"},      int'(dig1),      int'(e1));
    chk({tag, ".dig0"},      int'(dig0),      int'(e0));
    chk({tag, ".dig"},       int'(dig),       int'(eb));
    chk({tag, ".game_over"}, int'(game_over), int'(ego));
    chk({tag, ".playing"},   int'(playing),   int'(epl));
  endtask

  task automatic drive(input logic [4:0] in);
    {start, hit, miss, restart, frame_tick} = in;
    @(posedge clk);
    #1;
    {start, hit, miss, restart, frame_tick} = 5'b0;
  endtask

  task automatic add(input logic [4:0] in, input logic [3:0] e1, input logic [3:0] e0,
                     input logic [3:0] eb, input logic ego, input logic epl);
    vec_t v;
    v.in = in; v.e1 = e1; v.e0 = e0; v.eb = eb; v.ego = ego; v.epl = epl;
    vq.push_back(v);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    {start, hit, miss, restart, frame_tick} = 5'b0;

    // Inputs {start,hit,miss,restart,tick}; expected {dig1,dig0,dig,game_over,playing} after the edge
    add(5'b10000, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1); // start
    add(5'b01000, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    add(5'b01000, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    add(5'b01000, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    add(5'b00001, 4'd0, 4'd3, 4'd3, 1'b0, 1'b1); // tick shows 03
    add(5'b01001, 4'd0, 4'd3, 4'd3, 1'b0, 1'b1); // hit with tick: not in copy
    add(5'b00000, 4'd0, 4'd3, 4'd3, 1'b0, 1'b1);
    add(5'b00001, 4'd0, 4'd4, 4'd3, 1'b0, 1'b1); // shows next frame
    add(5'b00100, 4'd0, 4'd4, 4'd3, 1'b0, 1'b1);
    add(5'b00100, 4'd0, 4'd4, 4'd3, 1'b0, 1'b1);
    add(5'b00100, 4'd0, 4'd4, 4'd3, 1'b0, 1'b0); // last ball -> OVER
    add(5'b00001, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0);
    add(5'b01000, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0); // OVER ignores events
    add(5'b00100, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0);
    add(5'b10000, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0);
    add(5'b00001, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0);
    add(5'b01100, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0);
    add(5'b00001, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0);
    add(5'b10010, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0); // restart beats start
    add(5'b00001, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
    add(5'b01000, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0); // IDLE ignores hit/miss
    add(5'b00100, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
    add(5'b00001, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
    add(5'b10000, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    add(5'b00100, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    add(5'b00100, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    add(5'b01000, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    add(5'b01100, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0); // hit+miss on last ball
    add(5'b00001, 4'd0, 4'd2, 4'd0, 1'b1, 1'b0);
    add(5'b00010, 4'd0, 4'd2, 4'd0, 1'b1, 1'b0);
    add(5'b00001, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);

    #12;
    chk_all("reset", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].in);
      chk_all($sformatf("v%0d", i), vq[i].e1, vq[i].e0, vq[i].eb, vq[i].ego, vq[i].epl);
    end

    // BCD carry and saturation
    drive(5'b10000);
    for (int i = 0; i < 9; i++) drive(5'b01000);
    drive(5'b00001);
    chk_all("carry09", 4'd0, 4'd9, 4'd3, 1'b0, 1'b1);
    drive(5'b01000);
    drive(5'b00001);
    chk_all("carry10", 4'd1, 4'd0, 4'd3, 1'b0, 1'b1);
    for (int i = 0; i < 90; i++) drive(5'b01000);
    drive(5'b00001);
    chk_all("sat99", 4'd9, 4'd9, 4'd3, 1'b0, 1'b1);
    drive(5'b01000);
    drive(5'b00001);
    chk_all("sat99b", 4'd9, 4'd9, 4'd3, 1'b0, 1'b1);
    drive(5'b00100);
    drive(5'b00001);
    chk_all("premid", 4'd9, 4'd9, 4'd2, 1'b0, 1'b1);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(5'b10000);
    chk_all("post_start", 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    drive(5'b00001);
    chk_all("post_tick", 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
